// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand forwarding for the EX stage.
// Keeps a short history of instructions that already left EX and, each cycle,
// selects a forward source for RS/RT and flags load-use stalls.
// Optional build macro HAZARD_FWD_STATS_EN adds saturating stall/forward counters.
module hazard_forward_unit #(
  parameter int unsigned NSTAGES  = 2,
  parameter int unsigned AW       = 5,
  parameter int unsigned LOAD_LAT = 1,
  localparam int unsigned SW      = $clog2(NSTAGES + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ex_valid,
  input  logic [AW-1:0] ex_rs,
  input  logic [AW-1:0] ex_rt,
  input  logic          ex_use_rs,
  input  logic          ex_use_rt,
  input  logic [AW-1:0] ex_rd,
  input  logic          ex_we,
  input  logic          ex_is_load,
  input  logic          flush,
  output logic [SW-1:0] fa,
  output logic [SW-1:0] fb,
  output logic          stall
`ifdef HAZARD_FWD_STATS_EN
  ,
  output logic [31:0]   stall_cnt,
  output logic [31:0]   fwd_cnt
`endif
);

  // Entry k holds the instruction that left EX k cycles ago (1 = youngest).
  logic          hv_q  [1:NSTAGES];
  logic [AW-1:0] hrd_q [1:NSTAGES];
  logic          hwe_q [1:NSTAGES];
  logic          hld_q [1:NSTAGES];

  logic [SW-1:0] fa_sel, fb_sel;
  logic          fa_ld, fb_ld;

  // Youngest-match search per source; the loop runs oldest-first so the
  // last (smallest k) hit wins.
  always_comb begin
    fa_sel = '0;
    fb_sel = '0;
    fa_ld  = 1'b0;
    fb_ld  = 1'b0;
    for (int k = NSTAGES; k >= 1; k--) begin
      if (hv_q[k] && hwe_q[k] && (hrd_q[k] != '0) && (hrd_q[k] == ex_rs)) begin
        fa_sel = SW'(k);
        fa_ld  = hld_q[k] && (k <= int'(LOAD_LAT));
      end
      if (hv_q[k] && hwe_q[k] && (hrd_q[k] != '0) && (hrd_q[k] == ex_rt)) begin
        fb_sel = SW'(k);
        fb_ld  = hld_q[k] && (k <= int'(LOAD_LAT));
      end
    end
    fa    = (ex_valid && ex_use_rs) ? fa_sel : '0;
    fb    = (ex_valid && ex_use_rt) ? fb_sel : '0;
    // A pending load result that is still too young stalls EX; flush cancels it.
    stall = ex_valid && !flush && !reset &&
            ((ex_use_rs && fa_ld) || (ex_use_rt && fb_ld));
  end

  // History shift register; a stall injects a bubble at entry 1, flush empties it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 1; k <= NSTAGES; k++) begin
        hv_q[k]  <= 1'b0;
        hrd_q[k] <= '0;
        hwe_q[k] <= 1'b0;
        hld_q[k] <= 1'b0;
      end
    end else begin
      for (int k = NSTAGES; k >= 2; k--) begin
        hv_q[k]  <= hv_q[k-1];
        hrd_q[k] <= hrd_q[k-1];
        hwe_q[k] <= hwe_q[k-1];
        hld_q[k] <= hld_q[k-1];
      end
      hv_q[1]  <= ex_valid && !stall;
      hrd_q[1] <= ex_rd;
      hwe_q[1] <= ex_we;
      hld_q[1] <= ex_is_load;
      if (flush) begin
        for (int k = 1; k <= NSTAGES; k++) begin
          hv_q[k] <= 1'b0;
        end
      end
    end
  end

`ifdef HAZARD_FWD_STATS_EN
  // Saturating counters of stall cycles and of cycles that actually forward.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (((fa != '0) || (fb != '0)) && !stall && (fwd_cnt != '1)) begin
        fwd_cnt <= fwd_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit: a default instance and a deeper
// NSTAGES=4 / LOAD_LAT=2 instance share the same stimulus.
module tb_hazard_forward_unit;

  typedef struct packed {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [4:0] rd;
    logic       we;
    logic       ld;
    logic       fl;
  } stim_t;

  typedef struct packed {
    logic [2:0] fa;
    logic [2:0] fb;
    logic       st;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ex_valid = 1'b0;
  logic [4:0] ex_rs = '0, ex_rt = '0, ex_rd = '0;
  logic       ex_use_rs = 1'b0, ex_use_rt = 1'b0;
  logic       ex_we = 1'b0, ex_is_load = 1'b0, flush = 1'b0;

  logic [1:0] fa0, fb0;
  logic       st0;
  logic [2:0] fa1, fb1;
  logic       st1;

  int vectors = 0;
  int miscompares = 0;
  exp_t sbq[$];

`ifdef HAZARD_FWD_STATS_EN
  logic [31:0] sc0, fc0, sc1, fc1;
`endif

  always #5 clk = ~clk;

  hazard_forward_unit d0 (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_use_rs(ex_use_rs), .ex_use_rt(ex_use_rt), .ex_rd(ex_rd), .ex_we(ex_we),
    .ex_is_load(ex_is_load), .flush(flush), .fa(fa0), .fb(fb0), .stall(st0)
`ifdef HAZARD_FWD_STATS_EN
    , .stall_cnt(sc0), .fwd_cnt(fc0)
`endif
  );

  hazard_forward_unit #(.NSTAGES(4), .AW(5), .LOAD_LAT(2)) d1 (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_use_rs(ex_use_rs), .ex_use_rt(ex_use_rt), .ex_rd(ex_rd), .ex_we(ex_we),
    .ex_is_load(ex_is_load), .flush(flush), .fa(fa1), .fb(fb1), .stall(st1)
`ifdef HAZARD_FWD_STATS_EN
    , .stall_cnt(sc1), .fwd_cnt(fc1)
`endif
  );

  function automatic stim_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                               input logic urs, input logic urt, input logic [4:0] rd,
                               input logic we, input logic ld, input logic fl);
    stim_t s;
    s.v = v; s.rs = rs; s.rt = rt; s.urs = urs; s.urt = urt;
    s.rd = rd; s.we = we; s.ld = ld; s.fl = fl;
    return s;
  endfunction

  function automatic exp_t ex(input int fa, input int fb, input logic st);
    exp_t e;
    e.fa = 3'(fa); e.fb = 3'(fb); e.st = st;
    return e;
  endfunction

  // Drive one EX-stage vector on the falling edge.
  task automatic apply(input stim_t s);
    @(negedge clk);
    ex_valid = s.v; ex_rs = s.rs; ex_rt = s.rt; ex_use_rs = s.urs; ex_use_rt = s.urt;
    ex_rd = s.rd; ex_we = s.we; ex_is_load = s.ld; flush = s.fl;
  endtask

  task automatic test_reset;
    stim_t s[3];
    exp_t  e[3];
    exp_t  got, obs;
    s[0] = mk(1, 3, 3, 1, 1, 3, 1, 0, 0); e[0] = ex(0, 0, 0);  // written while reset held
    s[1] = mk(1, 3, 0, 1, 0, 3, 1, 0, 0); e[1] = ex(0, 0, 0);  // history still empty
    s[2] = mk(1, 3, 0, 1, 0, 0, 0, 0, 0); e[2] = ex(1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      apply(s[i]);
      if (i == 1) reset = 1'b0;
      sbq.push_back(e[i]);
      #1;
      got = sbq.pop_front();
      obs = {1'b0, fa0, 1'b0, fb0, st0};
      vectors++;
      if (obs !== got) begin
        miscompares++;
        $display("FAIL reset[%0d]: got fa=%0d fb=%0d stall=%0d, expected fa=%0d fb=%0d stall=%0d",
                 i, obs.fa, obs.fb, obs.st, got.fa, got.fb, got.st);
      end
    end
  endtask

  task automatic test_forward_rs;
    stim_t s[3];
    exp_t  e[3];
    exp_t  got, obs;
    s[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1); e[0] = ex(0, 0, 0);
    s[1] = mk(1, 0, 0, 0, 0, 3, 1, 0, 0); e[1] = ex(0, 0, 0);  // add r3
    s[2] = mk(1, 3, 9, 1, 1, 0, 0, 0, 0); e[2] = ex(1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      apply(s[i]);
      sbq.push_back(e[i]);
      #1;
      got = sbq.pop_front();
      obs = {1'b0, fa0, 1'b0, fb0, st0};
      vectors++;
      if (obs !== got) begin
        miscompares++;
        $display("FAIL fwd_rs[%0d]: got fa=%0d fb=%0d stall=%0d, expected fa=%0d fb=%0d stall=%0d",
                 i, obs.fa, obs.fb, obs.st, got.fa, got.fb, got.st);
      end
    end
  endtask

  task automatic test_youngest;
    stim_t s[6];
    exp_t  e[6];
    exp_t  got, obs;
    s[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1); e[0] = ex(0, 0, 0);
    s[1] = mk(1, 0, 0, 0, 0, 4, 1, 0, 0); e[1] = ex(0, 0, 0);
    s[2] = mk(1, 0, 0, 0, 0, 4, 1, 0, 0); e[2] = ex(0, 0, 0);
    s[3] = mk(1, 4, 4, 0, 1, 0, 0, 0, 0); e[3] = ex(0, 1, 0);  // rs unused -> fa=0
    s[4] = mk(1, 4, 0, 1, 0, 0, 0, 0, 0); e[4] = ex(2, 0, 0);  // older r4 write at entry 2
    s[5] = mk(0, 4, 4, 1, 1, 0, 0, 0, 0); e[5] = ex(0, 0, 0);  // bubble never forwards
    for (int i = 0; i < 6; i++) begin
      apply(s[i]);
      sbq.push_back(e[i]);
      #1;
      got = sbq.pop_front();
      obs = {1'b0, fa0, 1'b0, fb0, st0};
      vectors++;
      if (obs !== got) begin
        miscompares++;
        $display("FAIL youngest[%0d]: got fa=%0d fb=%0d stall=%0d, expected fa=%0d fb=%0d stall=%0d",
                 i, obs.fa, obs.fb, obs.st, got.fa, got.fb, got.st);
      end
    end
  endtask

  task automatic test_load_use;
    stim_t s[7];
    exp_t  e[7];
    exp_t  got, obs;
    s[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1);   e[0] = ex(0, 0, 0);
    s[1] = mk(1, 0, 0, 0, 0, 5, 1, 1, 0);   e[1] = ex(0, 0, 0);  // lw r5
    s[2] = mk(1, 5, 5, 1, 0, 0, 0, 0, 0);   e[2] = ex(1, 0, 1);
    s[3] = mk(1, 5, 5, 1, 0, 0, 0, 0, 0);   e[3] = ex(2, 0, 0);
    s[4] = mk(1, 0, 0, 0, 0, 10, 1, 1, 0);  e[4] = ex(0, 0, 0);  // lw r10
    s[5] = mk(1, 0, 10, 0, 1, 0, 0, 0, 0);  e[5] = ex(0, 1, 1);
    s[6] = mk(1, 0, 10, 0, 1, 0, 0, 0, 0);  e[6] = ex(0, 2, 0);
    for (int i = 0; i < 7; i++) begin
      apply(s[i]);
      sbq.push_back(e[i]);
      #1;
      got = sbq.pop_front();
      obs = {1'b0, fa0, 1'b0, fb0, st0};
      vectors++;
      if (obs !== got) begin
        miscompares++;
        $display("FAIL load_use[%0d]: got fa=%0d fb=%0d stall=%0d, expected fa=%0d fb=%0d stall=%0d",
                 i, obs.fa, obs.fb, obs.st, got.fa, got.fb, got.st);
      end
    end
  endtask

  task automatic test_deep_load;
    stim_t s[5];
    exp_t  e[5];
    exp_t  got, obs;
    s[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1); e[0] = ex(0, 0, 0);
    s[1] = mk(1, 0, 0, 0, 0, 6, 1, 1, 0); e[1] = ex(0, 0, 0);  // lw r6
    s[2] = mk(1, 6, 0, 1, 0, 0, 0, 0, 0); e[2] = ex(1, 0, 1);
    s[3] = mk(1, 6, 0, 1, 0, 0, 0, 0, 0); e[3] = ex(2, 0, 1);
    s[4] = mk(1, 6, 0, 1, 0, 0, 0, 0, 0); e[4] = ex(3, 0, 0);
    for (int i = 0; i < 5; i++) begin
      apply(s[i]);
      sbq.push_back(e[i]);
      #1;
      got = sbq.pop_front();
      obs = {fa1, fb1, st1};
      vectors++;
      if (obs !== got) begin
        miscompares++;
        $display("FAIL deep_load[%0d]: got fa=%0d fb=%0d stall=%0d, expected fa=%0d fb=%0d stall=%0d",
                 i, obs.fa, obs.fb, obs.st, got.fa, got.fb, got.st);
      end
    end
  endtask

  task automatic test_zero_flush;
    stim_t s[9];
    exp_t  e[9];
    exp_t  got, obs;
    s[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1); e[0] = ex(0, 0, 0);
    s[1] = mk(1, 0, 0, 0, 0, 0, 1, 0, 0); e[1] = ex(0, 0, 0);  // write r0
    s[2] = mk(1, 0, 0, 1, 1, 0, 0, 0, 0); e[2] = ex(0, 0, 0);
    s[3] = mk(1, 0, 0, 0, 0, 7, 1, 0, 0); e[3] = ex(0, 0, 0);  // write r7
    s[4] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1); e[4] = ex(0, 0, 0);  // flush
    s[5] = mk(1, 7, 7, 1, 1, 0, 0, 0, 0); e[5] = ex(0, 0, 0);
    s[6] = mk(1, 0, 0, 0, 0, 8, 1, 1, 0); e[6] = ex(0, 0, 0);  // lw r8
    s[7] = mk(1, 8, 0, 1, 0, 0, 0, 0, 1); e[7] = ex(1, 0, 0);  // flush cycle: no stall
    s[8] = mk(1, 8, 0, 1, 0, 0, 0, 0, 0); e[8] = ex(0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      apply(s[i]);
      sbq.push_back(e[i]);
      #1;
      got = sbq.pop_front();
      obs = {1'b0, fa0, 1'b0, fb0, st0};
      vectors++;
      if (obs !== got) begin
        miscompares++;
        $display("FAIL zero_flush[%0d]: got fa=%0d fb=%0d stall=%0d, expected fa=%0d fb=%0d stall=%0d",
                 i, obs.fa, obs.fb, obs.st, got.fa, got.fb, got.st);
      end
    end
  endtask

  task automatic test_reset_mid_stall;
    stim_t s[7];
    exp_t  e[7];
    exp_t  got, obs;
    s[0] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1); e[0] = ex(0, 0, 0);
    s[1] = mk(1, 0, 0, 0, 0, 5, 1, 1, 0); e[1] = ex(0, 0, 0);  // lw r5
    s[2] = mk(1, 5, 0, 1, 0, 0, 0, 0, 0); e[2] = ex(1, 0, 1);
    s[3] = s[2];                          e[3] = ex(0, 0, 0);  // reset raised mid-cycle
    s[4] = mk(1, 5, 0, 1, 0, 0, 0, 0, 0); e[4] = ex(0, 0, 0);
    s[5] = mk(1, 5, 0, 1, 0, 9, 1, 0, 0); e[5] = ex(0, 0, 0);  // write r9
    s[6] = mk(1, 9, 0, 1, 0, 0, 0, 0, 0); e[6] = ex(1, 0, 0);
    for (int i = 0; i < 7; i++) begin
      if (i == 3) begin
        #1;
        reset = 1'b1;
      end else begin
        apply(s[i]);
        if (i == 4) reset = 1'b0;
      end
      sbq.push_back(e[i]);
      #1;
      got = sbq.pop_front();
      obs = {1'b0, fa0, 1'b0, fb0, st0};
      vectors++;
      if (obs !== got) begin
        miscompares++;
        $display("FAIL reset_mid_stall[%0d]: got fa=%0d fb=%0d stall=%0d, expected fa=%0d fb=%0d stall=%0d",
                 i, obs.fa, obs.fb, obs.st, got.fa, got.fb, got.st);
      end
    end
  endtask

  initial begin
    test_reset();
    test_forward_rs();
    test_youngest();
    test_load_use();
    test_deep_load();
    test_zero_flush();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_forward_unit.md
HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 SHALL have parameter NSTAGES, default 2, number of tracked older in-flight instructions (forward sources), range 2..7.
REQ-002 SHALL have parameter AW, default 5, register address width.
REQ-003 SHALL have parameter LOAD_LAT, default 1, cycles a load result is unavailable after leaving EX, range 1..NSTAGES-1.
REQ-004 SHALL derive SW = clog2(NSTAGES+1) as the width of each forward select.
REQ-005 SHALL use one clock, clk (rising edge); reset is asynchronous and active-high, named reset.
REQ-006 Port: clk, input, 1, clock.
REQ-007 Port: reset, input, 1, async active-high reset.
REQ-008 Port: ex_valid, input, 1, EX-stage instruction is real (0 = bubble).
REQ-009 Port: ex_rs / ex_rt, input, AW each, EX source addresses.
REQ-010 Port: ex_use_rs / ex_use_rt, input, 1 each, source actually read (R-type, SW, branch, output, HI/LO move set ex_use_rt).
REQ-011 Port: ex_rd, input, AW, EX destination address; ex_we, input, 1, writes register file; ex_is_load, input, 1, result from memory.
REQ-012 Port: flush, input, 1, discard all tracked in-flight instructions.
REQ-013 Port: fa / fb, output, SW each, forward select for RS / RT.
REQ-014 Port: stall, output, 1, hold EX instruction and upstream stages this cycle.

Function
REQ-015 SHALL keep history entries 1..NSTAGES, each {valid, rd, we, is_load}; entry k is the instruction that left EX k cycles ago, entry 1 youngest.
REQ-016 SHALL, each clock with stall=0, shift entry k into k+1, drop entry NSTAGES, and load entry 1 from {ex_valid, ex_rd, ex_we, ex_is_load}.
REQ-017 SHALL, each clock with stall=1, shift entries 2..NSTAGES as in REQ-016 and load entry 1 as invalid (bubble).
REQ-018 SHALL define match(k,src) = entry k valid AND we AND rd != 0 AND rd == src.
REQ-019 SHALL drive fa = smallest k with match(k,ex_rs), 0 if none or ex_use_rs=0 or ex_valid=0; fb likewise with ex_rt/ex_use_rt.
REQ-020 SHALL compute fa, fb, stall combinationally from current history and inputs (zero latency).
REQ-021 SHALL assert stall when ex_valid=1 and, for a used source, the smallest matching k has is_load=1 and k <= LOAD_LAT.
REQ-022 SHALL, while stall=1, still drive fa/fb per REQ-019; consumers ignore them until stall=0.
REQ-023 SHALL bound any single load-use stall to LOAD_LAT-k+1 consecutive cycles, after which the load sits at entry LOAD_LAT+1 and fa/fb selects it.
REQ-024 SHALL, on flush=1, clear every entry valid at the next edge (flush wins over shift); stall is forced 0 in the flush cycle.
REQ-025 SHALL treat address 0 as never matching, on either side.
REQ-026 SHALL give the youngest matching entry priority when several entries hold the same rd.

Reset
REQ-027 SHALL, while reset=1, clear all entry valid bits asynchronously; fa=0, fb=0, stall=0.
REQ-028 SHALL, when reset asserts mid-stall, drop the stall immediately and resume with empty history after release.

Configuration
REQ-029 SHALL, with macro HAZARD_FWD_STATS_EN defined, add outputs stall_cnt (32) and fwd_cnt (32): saturating counters of stall cycles and of cycles with fa!=0 or fb!=0 and stall=0, cleared by reset.
REQ-030 SHALL, without HAZARD_FWD_STATS_EN, omit both ports and counters; all other behaviour identical.

Verification
REQ-031 Defaults; add r3 then EX uses r3 as rs (use_rs=1) next cycle -> fa=1, fb=0, stall=0.
REQ-032 Defaults; writes to r4 two and one cycles back, EX uses r4 as rt -> fb=1 (youngest), fa=0.
REQ-033 Defaults; lw r5, next EX uses r5 as rs -> stall=1 one cycle, then fa=2, stall=0.
REQ-034 NSTAGES=4, LOAD_LAT=2; lw r6, next EX uses r6 -> stall 2 cycles, then fa=3.
REQ-035 Write to r0 one cycle back, EX uses r0 -> fa=0; write to r7, flush, EX uses r7 -> fa=0.
REQ-036 Reset asserted during REQ-033 stall -> stall=0 same cycle; after release, no forwarding until new writes.
